// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control FSM: opcode
// values, the 4-bit ALUOp codes handed to the ALU control decoder, the
// datapath mux encodings, the FSM state enum and the control-word struct.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  // ALUOp codes consumed by the ALU control decoder
  localparam logic [3:0] ALUOP_R      = 4'b1111;
  localparam logic [3:0] ALUOP_ADD    = 4'b0100;
  localparam logic [3:0] ALUOP_ORI    = 4'b0101;
  localparam logic [3:0] ALUOP_LUI    = 4'b0110;
  localparam logic [3:0] ALUOP_LW     = 4'b0001;
  localparam logic [3:0] ALUOP_SW     = 4'b0010;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0011;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_R_EXEC   = 4'd2,
    S_R_WB     = 4'd3,
    S_I_EXEC   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Datapath control word produced by the output decoder
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // State that follows DECODE for a given opcode; unknown opcodes return to FETCH
  function automatic state_t decode_next(input logic [5:0] op);
    state_t ns;
    case (op)
      OP_R:                    ns = S_R_EXEC;
      OP_ADDI, OP_ORI, OP_LUI: ns = S_I_EXEC;
      OP_LW, OP_SW:            ns = S_MEM_ADDR;
      OP_BEQ, OP_BNE:          ns = S_BRANCH;
      OP_J:                    ns = S_JUMP;
      default:                 ns = S_FETCH;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/multicycle_control_out_dec.sv
// multicycle_control_out_dec
// Combinational state -> control-word decode for the multicycle control FSM.
// Ports:
//   state     in   current FSM state
//   op_q      in   opcode latched in DECODE (selects ALUOp / branch sense)
//   mem_ready in   memory completes its access this cycle (gates FETCH pc/ir)
//   zero      in   ALU zero flag (resolves branches)
//   ctrl      out  datapath control word
module multicycle_control_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR load and PC+4 only happen on the cycle the instruction arrives
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_R;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (op_q)
          OP_ORI:  ctrl.alu_op = ALUOP_ORI;
          OP_LUI:  ctrl.alu_op = ALUOP_LUI;
          default: ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (op_q == OP_SW) ? ALUOP_SW : ALUOP_LW;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_BRANCH;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = ((op_q == OP_BEQ) & zero) | ((op_q == OP_BNE) & ~zero);
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for the multicycle MIPS datapath. Sequences
// FETCH/DECODE/EXECUTE/MEM/WB, handshakes with a stalling memory via
// mem_ready, and counts retired instructions.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode, zero          IR[31:26] and ALU zero flag
//   mem_ready             memory completes current access this cycle
//   mem_read..reg_write   datapath control outputs
//   illegal_op            one-cycle pulse in DECODE on an unknown opcode
//   retired               retired-instruction count (wraps)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  state_t     state, next_state, dec_state;
  logic [5:0] op_q;
  logic       retire;
  ctrl_t      ctrl;

  // While reset is held the outputs look like FETCH regardless of the
  // state register, so a reset mid-instruction cannot leak a write.
  assign dec_state = reset ? S_FETCH : state;

  multicycle_control_out_dec u_out_dec (
    .state     (dec_state),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE:   next_state = decode_next(opcode);
      S_R_EXEC:   next_state = S_R_WB;
      S_I_EXEC:   next_state = S_I_WB;
      S_MEM_ADDR: next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem_read   = ctrl.mem_read  & ~reset;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign ir_write   = ctrl.ir_write  & ~reset;
  assign pc_write   = ctrl.pc_write  & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign i_or_d     = ctrl.i_or_d;
  assign pc_source  = ctrl.pc_source;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign illegal_op = ~reset && (state == S_DECODE) && (decode_next(opcode) == S_FETCH);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed bench for multicycle_control. Two instances share stimulus:
// dut (CNT_W=32) and dut4 (CNT_W=4, for counter wrap). Each cycle the
// inputs are driven at the falling edge and the full control word is
// compared against hand-computed constants.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_source, alu_src_b;
  logic        alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  logic        d4_mem_read, d4_mem_write, d4_i_or_d, d4_ir_write, d4_pc_write;
  logic [1:0]  d4_pc_source, d4_alu_src_b;
  logic        d4_alu_src_a, d4_reg_dst, d4_mem_to_reg, d4_reg_write, d4_illegal_op;
  logic [3:0]  d4_alu_op;
  logic [3:0]  d4_retired;

  int vectors = 0;
  int miscompares = 0;

  // Opcodes
  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] J = 6'b000010, BAD = 6'b111111;

  // Control word: mr mw iod irw pcw pcs[2] asa asb[2] aluop[4] rd m2r rw ill
  localparam logic [17:0] W_FETCH_GO   = 18'b1_0_0_1_1_00_0_01_0100_0_0_0_0;
  localparam logic [17:0] W_FETCH_WAIT = 18'b1_0_0_0_0_00_0_01_0100_0_0_0_0;
  localparam logic [17:0] W_FETCH_RST  = 18'b0_0_0_0_0_00_0_01_0100_0_0_0_0;
  localparam logic [17:0] W_DECODE     = 18'b0_0_0_0_0_00_0_11_0100_0_0_0_0;
  localparam logic [17:0] W_DECODE_ILL = 18'b0_0_0_0_0_00_0_11_0100_0_0_0_1;
  localparam logic [17:0] W_R_EXEC     = 18'b0_0_0_0_0_00_1_00_1111_0_0_0_0;
  localparam logic [17:0] W_R_WB       = 18'b0_0_0_0_0_00_0_00_0000_1_0_1_0;
  localparam logic [17:0] W_I_ADDI     = 18'b0_0_0_0_0_00_1_10_0100_0_0_0_0;
  localparam logic [17:0] W_I_ORI      = 18'b0_0_0_0_0_00_1_10_0101_0_0_0_0;
  localparam logic [17:0] W_I_WB       = 18'b0_0_0_0_0_00_0_00_0000_0_0_1_0;
  localparam logic [17:0] W_MA_LW      = 18'b0_0_0_0_0_00_1_10_0001_0_0_0_0;
  localparam logic [17:0] W_MA_SW      = 18'b0_0_0_0_0_00_1_10_0010_0_0_0_0;
  localparam logic [17:0] W_MEM_RD     = 18'b1_0_1_0_0_00_0_00_0000_0_0_0_0;
  localparam logic [17:0] W_MEM_WB     = 18'b0_0_0_0_0_00_0_00_0000_0_1_1_0;
  localparam logic [17:0] W_MEM_WR     = 18'b0_1_1_0_0_00_0_00_0000_0_0_0_0;
  localparam logic [17:0] W_BR_TAKEN   = 18'b0_0_0_0_1_01_1_00_0011_0_0_0_0;
  localparam logic [17:0] W_BR_NOT     = 18'b0_0_0_0_0_01_1_00_0011_0_0_0_0;
  localparam logic [17:0] W_JUMP       = 18'b0_0_0_0_1_10_0_00_0000_0_0_0_0;

  logic [17:0] obs;
  assign obs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal_op};

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal_op(illegal_op), .retired(retired)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(d4_mem_read), .mem_write(d4_mem_write), .i_or_d(d4_i_or_d),
    .ir_write(d4_ir_write), .pc_write(d4_pc_write), .pc_source(d4_pc_source),
    .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op),
    .reg_dst(d4_reg_dst), .mem_to_reg(d4_mem_to_reg), .reg_write(d4_reg_write),
    .illegal_op(d4_illegal_op), .retired(d4_retired)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge, then settle before checking
  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic z, input logic mr);
    @(negedge clk);
    reset     = r;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] multicycle_control directed test");

    // Reset for two cycles
    applyStimulus(1, R, 0, 1);   checkOutput("rst_c1", {14'd0, obs}, {14'd0, W_FETCH_RST});
    applyStimulus(1, R, 0, 1);   checkOutput("rst_c2", {14'd0, obs}, {14'd0, W_FETCH_RST});
    checkOutput("rst_ret", retired, 32'd0);
    checkOutput("rst_ret4", {28'd0, d4_retired}, 32'd0);

    // SW stalled in MEM_WR, aborted by reset (mem_ready high on the reset cycle)
    applyStimulus(0, SW, 0, 1);  checkOutput("swa_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    applyStimulus(0, SW, 0, 1);  checkOutput("swa_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, SW, 0, 1);  checkOutput("swa_addr", {14'd0, obs}, {14'd0, W_MA_SW});
    applyStimulus(0, SW, 0, 0);  checkOutput("swa_stall", {14'd0, obs}, {14'd0, W_MEM_WR});
    applyStimulus(1, SW, 0, 1);  checkOutput("swa_rst", {14'd0, obs}, {14'd0, W_FETCH_RST});

    // R-type: 4 cycles
    applyStimulus(0, R, 0, 1);   checkOutput("abort_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("abort_ret", retired, 32'd0);
    applyStimulus(0, R, 0, 1);   checkOutput("r_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, R, 0, 1);   checkOutput("r_exec", {14'd0, obs}, {14'd0, W_R_EXEC});
    applyStimulus(0, R, 0, 1);   checkOutput("r_wb", {14'd0, obs}, {14'd0, W_R_WB});

    // ADDI
    applyStimulus(0, ADDI, 0, 1); checkOutput("addi_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("r_ret", retired, 32'd1);
    applyStimulus(0, ADDI, 0, 1); checkOutput("addi_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, ADDI, 0, 1); checkOutput("addi_exec", {14'd0, obs}, {14'd0, W_I_ADDI});
    applyStimulus(0, ADDI, 0, 1); checkOutput("addi_wb", {14'd0, obs}, {14'd0, W_I_WB});

    // ORI, with the opcode input changed to LUI after DECODE (must be ignored)
    applyStimulus(0, ORI, 0, 1); checkOutput("ori_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("addi_ret", retired, 32'd2);
    applyStimulus(0, ORI, 0, 1); checkOutput("ori_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, LUI, 0, 1); checkOutput("ori_exec", {14'd0, obs}, {14'd0, W_I_ORI});
    applyStimulus(0, LUI, 0, 1); checkOutput("ori_wb", {14'd0, obs}, {14'd0, W_I_WB});

    // LW with a 3-cycle stall in MEM_RD: 8 cycles total
    applyStimulus(0, LW, 0, 1);  checkOutput("lw_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("ori_ret", retired, 32'd3);
    applyStimulus(0, LW, 0, 1);  checkOutput("lw_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, LW, 0, 1);  checkOutput("lw_addr", {14'd0, obs}, {14'd0, W_MA_LW});
    applyStimulus(0, LW, 0, 0);  checkOutput("lw_rd_s1", {14'd0, obs}, {14'd0, W_MEM_RD});
    applyStimulus(0, LW, 0, 0);  checkOutput("lw_rd_s2", {14'd0, obs}, {14'd0, W_MEM_RD});
    applyStimulus(0, LW, 0, 0);  checkOutput("lw_rd_s3", {14'd0, obs}, {14'd0, W_MEM_RD});
    checkOutput("lw_stall_ret", retired, 32'd3);
    applyStimulus(0, LW, 0, 1);  checkOutput("lw_rd_go", {14'd0, obs}, {14'd0, W_MEM_RD});
    applyStimulus(0, LW, 0, 1);  checkOutput("lw_wb", {14'd0, obs}, {14'd0, W_MEM_WB});

    // SW with a one-cycle stall in FETCH
    applyStimulus(0, SW, 0, 0);  checkOutput("sw_fetch_wait", {14'd0, obs}, {14'd0, W_FETCH_WAIT});
    checkOutput("lw_ret", retired, 32'd4);
    applyStimulus(0, SW, 0, 1);  checkOutput("sw_fetch_go", {14'd0, obs}, {14'd0, W_FETCH_GO});
    applyStimulus(0, SW, 0, 1);  checkOutput("sw_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, SW, 0, 1);  checkOutput("sw_addr", {14'd0, obs}, {14'd0, W_MA_SW});
    applyStimulus(0, SW, 0, 1);  checkOutput("sw_wr", {14'd0, obs}, {14'd0, W_MEM_WR});

    // BEQ with zero=1: taken
    applyStimulus(0, BEQ, 1, 1); checkOutput("beq_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("sw_ret", retired, 32'd5);
    applyStimulus(0, BEQ, 1, 1); checkOutput("beq_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, BEQ, 1, 1); checkOutput("beq_z1", {14'd0, obs}, {14'd0, W_BR_TAKEN});

    // BNE with zero=1: not taken
    applyStimulus(0, BNE, 1, 1); checkOutput("bne_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("beq_ret", retired, 32'd6);
    applyStimulus(0, BNE, 1, 1); checkOutput("bne_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, BNE, 1, 1); checkOutput("bne_z1", {14'd0, obs}, {14'd0, W_BR_NOT});

    // BEQ with zero=0: not taken
    applyStimulus(0, BEQ, 0, 1); checkOutput("beq0_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("bne_ret", retired, 32'd7);
    applyStimulus(0, BEQ, 0, 1); checkOutput("beq0_dec", {14'd0, obs}, {14'd0, W_DECODE});
    applyStimulus(0, BEQ, 0, 1); checkOutput("beq_z0", {14'd0, obs}, {14'd0, W_BR_NOT});

    // Illegal opcode: pulse in DECODE, straight back to FETCH, no retire
    applyStimulus(0, BAD, 0, 1); checkOutput("ill_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("beq0_ret", retired, 32'd8);
    applyStimulus(0, BAD, 0, 1); checkOutput("ill_dec", {14'd0, obs}, {14'd0, W_DECODE_ILL});
    applyStimulus(0, BAD, 0, 1); checkOutput("ill_back", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("ill_ret", retired, 32'd8);
    checkOutput("ill_ret4", {28'd0, d4_retired}, 32'd8);

    // Reset, then 16 jumps: the 4-bit counter wraps to 0
    applyStimulus(1, J, 0, 1);   checkOutput("j_rst", {14'd0, obs}, {14'd0, W_FETCH_RST});
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, J, 0, 1); checkOutput("j_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
      checkOutput("j_ret", retired, 32'(i));
      checkOutput("j_ret4", {28'd0, d4_retired}, 32'(i % 16));
      applyStimulus(0, J, 0, 1); checkOutput("j_dec", {14'd0, obs}, {14'd0, W_DECODE});
      applyStimulus(0, J, 0, 1); checkOutput("j_jump", {14'd0, obs}, {14'd0, W_JUMP});
    end
    applyStimulus(0, R, 0, 1);   checkOutput("j_end_fetch", {14'd0, obs}, {14'd0, W_FETCH_GO});
    checkOutput("j_end_ret", retired, 32'd16);
    checkOutput("j_wrap_ret4", {28'd0, d4_retired}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
